// File: rtl/opl_frac_clk_en_pkg.sv
// ---------------------------------------------------------------------------
// opl_frac_clk_en_pkg
//   Shared OPL constants for the sample clock-enable generator: the
//   accumulator width, the default INC/MOD ratio, the timer sample divisors
//   and a packed {inc, mod} ratio record.
// ---------------------------------------------------------------------------
package opl_frac_clk_en_pkg;

    // Phase accumulator / ratio width. MOD must stay below 2**width.
    localparam int OPL_SAMPLE_ACC_WIDTH = 29;

    // 24.576 MHz * 715909 / 353894400 = 49.7159 kHz (494.33 clk per sample).
    localparam int unsigned OPL_SAMPLE_INC_DEFAULT = 715909;
    localparam int unsigned OPL_SAMPLE_MOD_DEFAULT = 353894400;

    // Timer tick divisors, in samples.
    localparam int OPL_TIMER1_SAMPLE_DIV = 4;
    localparam int OPL_TIMER2_SAMPLE_DIV = 16;

    // One programmable ratio.
    typedef struct packed {
        logic [OPL_SAMPLE_ACC_WIDTH-1:0] inc;
        logic [OPL_SAMPLE_ACC_WIDTH-1:0] mod;
    } clk_en_cfg_t;

endpackage

// File: rtl/opl_frac_clk_en_if.sv
// ---------------------------------------------------------------------------
// opl_frac_clk_en_if
//   Ratio-configuration handshake plus the generated strobes.
//   slave  : the clock-enable generator (accepts ratios, drives strobes)
//   master : the controller / consumer side
//   Signals:
//     cfg_valid/cfg_ready  ratio transfer handshake
//     cfg_inc/cfg_mod      offered ratio
//     cfg_err              one-cycle pulse for a rejected ratio
//     cfg_pending          accepted ratio waiting for its apply point
//     sample_clk_en        one-cycle sample strobe
//     tick_en              one-cycle timer tick strobes
// ---------------------------------------------------------------------------
interface opl_frac_clk_en_if
    import opl_frac_clk_en_pkg::*;
#(
    parameter int ACC_WIDTH = OPL_SAMPLE_ACC_WIDTH,
    parameter int NUM_TICKS = 2
) ();

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [ACC_WIDTH-1:0] cfg_inc;
    logic [ACC_WIDTH-1:0] cfg_mod;
    logic                 cfg_err;
    logic                 cfg_pending;
    logic                 sample_clk_en;
    logic [NUM_TICKS-1:0] tick_en;

    modport slave (
        input  cfg_valid,
        input  cfg_inc,
        input  cfg_mod,
        output cfg_ready,
        output cfg_err,
        output cfg_pending,
        output sample_clk_en,
        output tick_en
    );

    modport master (
        output cfg_valid,
        output cfg_inc,
        output cfg_mod,
        input  cfg_ready,
        input  cfg_err,
        input  cfg_pending,
        input  sample_clk_en,
        input  tick_en
    );

endinterface

// File: rtl/opl_frac_clk_en_tick_div.sv
// ---------------------------------------------------------------------------
// opl_tick_div
//   Modulo-DIV counter of sample strobes with a registered tick output.
//   Ports:
//     clk            audio clock
//     ic_n           asynchronous active-low reset
//     sample_clk_en  wrap indication for the current edge (pre-register)
//     tick_en        registered one-cycle tick, aligned with the registered
//                    sample strobe of the parent
// ---------------------------------------------------------------------------
module opl_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic ic_n,
    input  logic sample_clk_en,
    output logic tick_en
);

    // A divide-by-one still needs a 1-bit counter; it simply never leaves 0.
    localparam int            CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (sample_clk_en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_en = tick_q;

endmodule

// File: rtl/opl_frac_clk_en.sv
// ---------------------------------------------------------------------------
// opl_frac_clk_en
//   Fractional-N sample clock-enable generator. A phase accumulator advances
//   by INC each enabled cycle and wraps modulo MOD; every wrap produces a
//   one-cycle sample strobe, giving an exact average rate of f_clk*INC/MOD.
//   NUM_TICKS timer strobes are derived by dividing the sample strobe.
//   Ports:
//     clk     audio clock
//     ic_n    asynchronous active-low reset
//     enable  run; low freezes all state and suppresses strobes
//     bus     ratio handshake and strobe outputs (slave side)
// ---------------------------------------------------------------------------
module opl_frac_clk_en
    import opl_frac_clk_en_pkg::*;
#(
    parameter int          ACC_WIDTH   = OPL_SAMPLE_ACC_WIDTH,
    parameter int unsigned DEFAULT_INC = OPL_SAMPLE_INC_DEFAULT,
    parameter int unsigned DEFAULT_MOD = OPL_SAMPLE_MOD_DEFAULT,
    parameter int          NUM_TICKS   = 2,
    parameter int          TICK_DIV [NUM_TICKS] = '{OPL_TIMER1_SAMPLE_DIV,
                                                    OPL_TIMER2_SAMPLE_DIV}
) (
    input  logic             clk,
    input  logic             ic_n,
    input  logic             enable,
    opl_frac_clk_en_if.slave bus
);

    localparam logic [ACC_WIDTH-1:0] DEF_INC = DEFAULT_INC[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] DEF_MOD = DEFAULT_MOD[ACC_WIDTH-1:0];

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] inc_q, inc_d;
    logic [ACC_WIDTH-1:0] mod_q, mod_d;
    logic [ACC_WIDTH-1:0] sh_inc_q, sh_inc_d;
    logic [ACC_WIDTH-1:0] sh_mod_q, sh_mod_d;
    logic                 pending_q, pending_d;
    logic                 sample_q, sample_d;
    logic                 err_q, err_d;

    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] sum_wrapped;
    logic                 wrap;
    logic                 apply;
    logic                 xfer;
    logic                 cfg_ok;
    logic [NUM_TICKS-1:0] tick_en_w;

    always_comb begin
        // One extra bit so acc + inc can never overflow before the compare.
        sum         = {1'b0, acc_q} + {1'b0, inc_q};
        // acc < mod and inc <= mod keep the true difference below mod, so
        // the low bits alone carry the exact result.
        sum_wrapped = sum[ACC_WIDTH-1:0] - mod_q;
        wrap        = enable && (sum >= {1'b0, mod_q});

        // Enabled: a pending ratio waits for a wrap so the current period
        // finishes on the old ratio. Disabled: nothing is running, take it now.
        apply  = pending_q && (wrap || !enable);
        xfer   = bus.cfg_valid && !pending_q;
        cfg_ok = (bus.cfg_inc != '0) && (bus.cfg_mod != '0) &&
                 (bus.cfg_inc <= bus.cfg_mod);

        acc_d     = acc_q;
        inc_d     = inc_q;
        mod_d     = mod_q;
        sh_inc_d  = sh_inc_q;
        sh_mod_d  = sh_mod_q;
        pending_d = pending_q;

        if (enable) begin
            acc_d = wrap ? sum_wrapped : sum[ACC_WIDTH-1:0];
        end

        if (apply) begin
            inc_d     = sh_inc_q;
            mod_d     = sh_mod_q;
            acc_d     = '0;
            pending_d = 1'b0;
        end

        // Transfer and apply never coincide: a transfer needs pending low.
        if (xfer && cfg_ok) begin
            sh_inc_d  = bus.cfg_inc;
            sh_mod_d  = bus.cfg_mod;
            pending_d = 1'b1;
        end

        sample_d = wrap;
        err_d    = xfer && !cfg_ok;
    end

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            acc_q     <= '0;
            inc_q     <= DEF_INC;
            mod_q     <= DEF_MOD;
            sh_inc_q  <= DEF_INC;
            sh_mod_q  <= DEF_MOD;
            pending_q <= 1'b0;
            sample_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            mod_q     <= mod_d;
            sh_inc_q  <= sh_inc_d;
            sh_mod_q  <= sh_mod_d;
            pending_q <= pending_d;
            sample_q  <= sample_d;
            err_q     <= err_d;
        end
    end

    // Tick dividers see the unregistered wrap so their registered strobes
    // line up with the registered sample strobe.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TICKS; gi++) begin : g_tick
            opl_tick_div #(
                .DIV (TICK_DIV[gi])
            ) u_tick_div (
                .clk           (clk),
                .ic_n          (ic_n),
                .sample_clk_en (wrap),
                .tick_en       (tick_en_w[gi])
            );
        end
    endgenerate

    assign bus.cfg_ready     = !pending_q;
    assign bus.cfg_pending   = pending_q;
    assign bus.cfg_err       = err_q;
    assign bus.sample_clk_en = sample_q;
    assign bus.tick_en       = tick_en_w;

endmodule

// File: tb/tb_opl_frac_clk_en.sv
module tb_opl_frac_clk_en;
    import opl_frac_clk_en_pkg::*;

    localparam int AW = OPL_SAMPLE_ACC_WIDTH;
    localparam int NT = 2;

    int divs [NT] = '{4, 16};

    logic clk    = 1'b0;
    logic ic_n   = 1'b0;
    logic enable = 1'b0;

    opl_frac_clk_en_if #(.ACC_WIDTH(AW), .NUM_TICKS(NT)) bus ();

    opl_frac_clk_en #(
        .ACC_WIDTH   (AW),
        .DEFAULT_INC (715909),
        .DEFAULT_MOD (353894400),
        .NUM_TICKS   (NT),
        .TICK_DIV    ('{4, 16})
    ) dut (
        .clk    (clk),
        .ic_n   (ic_n),
        .enable (enable),
        .bus    (bus)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase after k enabled edges since the last reset/apply is k*inc; a
    // sample falls on edge k whenever floor(k*inc/mod) steps up.
    longint m_inc, m_mod, s_inc, s_mod, m_k, m_samp;
    bit     m_pend;
    bit     e_smp, e_err;
    bit [NT-1:0] e_tick;

    task automatic model_reset();
        m_inc = 715909; m_mod = 353894400;
        s_inc = 715909; s_mod = 353894400;
        m_k = 0; m_samp = 0; m_pend = 0;
        e_smp = 0; e_err = 0; e_tick = '0;
    endtask

    task automatic model_step();
        longint ci, cm;
        bit w, ap, xf, ok;
        ci = longint'(bus.cfg_inc);
        cm = longint'(bus.cfg_mod);
        w  = 0;
        if (enable) begin
            m_k++;
            w = ((m_k * m_inc) / m_mod) != (((m_k - 1) * m_inc) / m_mod);
        end
        e_smp  = w;
        e_tick = '0;
        if (w) begin
            m_samp++;
            for (int i = 0; i < NT; i++) e_tick[i] = ((m_samp % divs[i]) == 0);
        end
        ap = m_pend && (!enable || w);
        xf = bus.cfg_valid && !m_pend;
        ok = (ci != 0) && (cm != 0) && (ci <= cm);
        e_err = xf && !ok;
        if (ap) begin
            m_inc = s_inc; m_mod = s_mod; m_k = 0; m_pend = 0;
        end
        if (xf && ok) begin
            s_inc = ci; s_mod = cm; m_pend = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge ic_n);
            if (!ic_n) model_reset();
            else       model_step();
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("sample_clk_en", bus.sample_clk_en, e_smp);
        check("tick_en",       bus.tick_en,       e_tick);
        check("cfg_err",       bus.cfg_err,       e_err);
        check("cfg_ready",     bus.cfg_ready,     !m_pend);
        check("cfg_pending",   bus.cfg_pending,   m_pend);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wait_pulse(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sample_clk_en !== 1'b1 && n < limit);
        check("pulse_seen", bus.sample_clk_en, 1);
    endtask

    task automatic offer(input longint i, input longint m);
        bus.cfg_valid = 1'b1;
        bus.cfg_inc   = AW'(i);
        bus.cfg_mod   = AW'(m);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 ic_n = 1'b0;
        #1;
        check("rst_sample", bus.sample_clk_en, 0);
        check("rst_tick",   bus.tick_en,       0);
        check("rst_err",    bus.cfg_err,       0);
        check("rst_ready",  bus.cfg_ready,     1);
        check("rst_pend",   bus.cfg_pending,   0);
        @(negedge clk);
        @(negedge clk);
        ic_n = 1'b1;
    endtask

    clk_en_cfg_t bad_cfg [2];
    int exp_edges [4] = '{3, 5, 8, 10};

    initial begin
        int n, cnt, edge_no;
        bus.cfg_valid = 1'b0;
        bus.cfg_inc   = '0;
        bus.cfg_mod   = '0;
        bad_cfg[0] = '{inc: AW'(6), mod: AW'(5)};
        bad_cfg[1] = '{inc: AW'(0), mod: AW'(5)};

        repeat (3) @(negedge clk);
        check("reset_ready", bus.cfg_ready, 1);
        check("reset_sample", bus.sample_clk_en, 0);

        // Defaults: first pulse after edge 495, then 494/495 spacing.
        ic_n = 1'b1; enable = 1'b1;
        wait_pulse(n, 1000);
        check("first_pulse_edge", n, 495);
        wait_pulse(n, 1000);
        check("gap_494_or_495", (n == 494 || n == 495), 1);
        $display("default ratio: second gap %0d", n);

        // Long-run count: floor(20000*715909/353894400) = 40.
        do_reset();
        cnt = 0;
        repeat (20000) begin
            @(negedge clk);
            cnt += int'(bus.sample_clk_en);
        end
        check("pulses_in_20000", cnt, 40);
        $display("20000 enabled edges: %0d pulses", cnt);

        // 2/5 loaded while idle, applied on the next edge.
        enable = 1'b0;
        do_reset();
        offer(2, 5);
        check("pend_after_load", bus.cfg_pending, 1);
        @(negedge clk);
        check("applied_idle", bus.cfg_pending, 0);
        enable = 1'b1;
        edge_no = 0;
        for (int p = 1; p <= 16; p++) begin
            wait_pulse(n, 20);
            edge_no += n;
            if (p <= 4) check("edge_2_5", edge_no, exp_edges[p-1]);
            check("tick0_at_pulse", bus.tick_en[0], (p % 4) == 0);
            check("tick1_at_pulse", bus.tick_en[1], p == 16);
            $display("2/5 pulse %0d at edge %0d tick=%b", p, edge_no, bus.tick_en);
        end

        // Tick counter 0 at 3, ratio pending, then reset.
        repeat (3) wait_pulse(n, 20);
        offer(1, 3);
        check("pend_before_rst", bus.cfg_pending, 1);
        do_reset();
        wait_pulse(n, 1000);
        check("first_after_rst", n, 495);

        // Rejected ratios.
        for (int b = 0; b < 2; b++) begin
            offer(longint'(bad_cfg[b].inc), longint'(bad_cfg[b].mod));
            check("err_pulse", bus.cfg_err, 1);
            check("ready_on_err", bus.cfg_ready, 1);
            $display("offer %0d/%0d: cfg_err=%b", bad_cfg[b].inc, bad_cfg[b].mod, bus.cfg_err);
        end
        @(negedge clk);
        check("err_one_cycle", bus.cfg_err, 0);

        // 1/3 accepted mid-stream, second offer while pending ignored.
        wait_pulse(n, 1000);
        offer(1, 3);
        check("pend_mid", bus.cfg_pending, 1);
        check("ready_mid", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b1; bus.cfg_inc = AW'(1); bus.cfg_mod = AW'(2);
        repeat (3) @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("no_err_pending", bus.cfg_err, 0);
        wait_pulse(n, 1000);
        check("pend_cleared", bus.cfg_pending, 0);
        wait_pulse(n, 20);
        check("gap_1_3_a", n, 3);
        wait_pulse(n, 20);
        check("gap_1_3_b", n, 3);

        // Enable low for 100 cycles right after a wrap.
        @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        enable = 1'b1;
        wait_pulse(n, 20);
        check("gap_with_pause", 101 + n, 103);
        $display("pause: pulse %0d cycles after previous", 101 + n);

        // INC == MOD: strobe on every enabled cycle.
        offer(7, 7);
        wait_pulse(n, 20);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(bus.sample_clk_en);
        end
        check("inc_eq_mod", cnt, 20);

        // Randomised ratios, enables and offers against the model.
        for (int i = 0; i < 20000; i++) begin
            int unsigned m;
            enable = ($urandom_range(0, 9) != 0);
            m = $urandom_range(1, 40);
            bus.cfg_mod = AW'(m);
            bus.cfg_inc = AW'($urandom_range(0, m + 2));
            bus.cfg_valid = ($urandom_range(0, 49) == 0);
            if (i == 10000) do_reset();
            else @(negedge clk);
        end
        bus.cfg_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
